instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle datapath: takes the datapath's 10-bit word-addressed PC and returns the 16-bit Instruction plus a stall.
- Fetches from a variable-latency instruction memory over a req/ack handshake.
- Keeps a one-entry address-tagged instruction buffer, so a repeated PC (stalled datapath) hits with no further memory traffic.
- Bus timeout raises a sticky fetch error; a miss counter supports performance debug.

Parameters:
ADDR_W, 10, PC / instruction memory word-address width
DATA_W, 16, instruction width
TIMEOUT, 255, max cycles in WAIT without mem_ack before error (>=1)
NOP_INSTR, 16'h0000, value driven on instr when instr_valid=0

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
pc  input  ADDR_W  current PC from datapath
flush  input  1  invalidate buffer (instruction memory rewritten)
instr  output  DATA_W  instruction to datapath; NOP_INSTR when not valid
instr_valid  output  1  instr corresponds to pc this cycle
stall  output  1  = ~instr_valid; datapath must hold PC and suppress all writes
mem_req  output  1  read request to instruction memory
mem_addr  output  ADDR_W  read address; stable while mem_req=1
mem_ack  input  1  read data valid this cycle
mem_rdata  input  DATA_W  read data, sampled when mem_ack=1 in WAIT
fetch_err  output  1  sticky timeout error
miss_count  output  16  saturating count of issued memory requests

Behaviour:
- Registers: buf_valid, buf_addr[ADDR_W], buf_data[DATA_W], req_addr[ADDR_W], wait_cnt, state, fetch_err, miss_count.
- Reset (sync, priority over everything): state=IDLE, buf_valid=0, buf_addr=0, buf_data=0, req_addr=0, wait_cnt=0, fetch_err=0, miss_count=0. Outputs after reset: mem_req=0, mem_addr=0, instr=NOP_INSTR, instr_valid=0, stall=1.
- hit = buf_valid & (buf_addr==pc) & (state!=ERROR), combinational. instr=hit?buf_data:NOP_INSTR; instr_valid=hit; stall=~hit.
- mem_req = (state==WAIT); mem_addr = req_addr (registered, never pc directly).
- IDLE:
  - On ~hit and no flush: req_addr<=pc, wait_cnt<=0, miss_count+=1 (saturates at 16'hFFFF), go WAIT.
  - On hit: stay.
  - mem_ack in IDLE is ignored.
- WAIT:
  - On mem_ack: buf_data<=mem_rdata, buf_addr<=req_addr, buf_valid<=1, go IDLE.
  - Otherwise, if wait_cnt==TIMEOUT-1: go ERROR, fetch_err<=1. Else wait_cnt+=1.
  - mem_ack on the timeout cycle: ack wins, no error.
  - pc changing during WAIT does not disturb the request. Data is still buffered under req_addr; the next IDLE cycle compares against the new pc.
- DRAIN (flush while WAIT): keep mem_req=1 with the same address, since a bus request cannot be aborted.
  - On mem_ack: discard data, buf_valid stays 0, go IDLE.
  - Timeout rules are identical to WAIT.
- flush:
  - buf_valid<=0 on the edge in any state. instr_valid drops the following cycle.
  - In WAIT: go DRAIN.
  - In IDLE: no request is issued that cycle, even on a miss.
  - flush in DRAIN: no extra effect.
- ERROR: mem_req=0, instr_valid=0, stall=1, fetch_err=1. Exited only by reset; flush has no effect.
- Latency: miss detected in cycle N -> mem_req high N+1. With ack in N+1, instr_valid high in N+2 (2-cycle minimum miss penalty). With ack after k WAIT cycles, instr_valid high k+1 cycles after the miss cycle. Hit: 0 cycles.
- Reset during WAIT/DRAIN: mem_req low the next cycle. A late mem_ack then lands in IDLE and is ignored.

Test Plan:
- Reset, then pc=10'h000 with memory acking 1 cycle after req and mem_rdata=16'h1234 -> mem_req high cycle 1 with mem_addr=0; instr_valid=1 and instr=16'h1234 in cycle 2; miss_count=1.
- Hold pc=0 for 10 more cycles -> no further mem_req; instr stays 16'h1234; miss_count stays 1. Then pc=1 with a 3-cycle ack latency and data 16'hABCD -> stall=1 for 4 cycles, then instr=16'hABCD; miss_count=2.
- pc=5, then pc=6 while still in WAIT; ack returns 16'h5555 -> buffer tagged 5, no valid output for pc 6; a new request issues with mem_addr=6.
- Assert flush in the WAIT cycle of a pc=7 fetch, ack data 16'h7777 -> mem_req held through ack; instr_valid stays 0; a fresh request for 7 issues afterwards; miss_count increments twice.
- TIMEOUT=4, memory never acks -> mem_req high exactly 4 cycles, then fetch_err=1, mem_req=0, stall=1 permanently. Repeat with ack on the 4th WAIT cycle -> no error. Reset clears fetch_err.
- Reset asserted mid-WAIT, then a stray mem_ack the next cycle -> outputs at reset values; the stray ack is ignored; the next fetch proceeds normally.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-entry address-tagged instruction buffer in front of a variable-latency
// req/ack instruction memory, with sticky bus-timeout error and a saturating miss counter.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W    = 10,
    parameter int unsigned          DATA_W    = 16,
    parameter int unsigned          TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [ADDR_W-1:0]   i_pc,
    input  logic                i_flush,
    output logic [DATA_W-1:0]   o_instr,
    output logic                o_instr_valid,
    output logic                o_stall,
    output logic                o_mem_req,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_fetch_err,
    output logic [15:0]         o_miss_count
);

    localparam int unsigned     CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]     MISS_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_addr;
    logic [DATA_W-1:0]   r_buf_data;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_fetch_err;
    logic [15:0]         r_miss_count;

    logic                w_hit;
    logic                w_busy;
    logic                w_timeout;

    assign w_hit     = r_buf_valid && (r_buf_addr == i_pc) && (r_state != S_ERROR);
    assign w_busy    = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign w_timeout = (r_wait_cnt == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An outstanding bus read cannot be aborted, so a flush in WAIT drains it instead.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_flush && !w_hit) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_ack)      w_next_state = S_IDLE;
                else if (w_timeout) w_next_state = S_ERROR;
                else if (i_flush)   w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_mem_ack)      w_next_state = S_IDLE;
                else if (w_timeout) w_next_state = S_ERROR;
            end
            S_ERROR: begin
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_mem_req     = w_busy;
        o_mem_addr    = r_req_addr;
        o_instr_valid = w_hit;
        o_stall       = !w_hit;
        o_instr       = w_hit ? r_buf_data : NOP_INSTR;
        o_fetch_err   = r_fetch_err;
        o_miss_count  = r_miss_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_data   <= '0;
            r_req_addr   <= '0;
            r_wait_cnt   <= '0;
            r_fetch_err  <= 1'b0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_flush && !w_hit) begin
                        r_req_addr <= i_pc;
                        r_wait_cnt <= '0;
                        if (r_miss_count != MISS_MAX) r_miss_count <= r_miss_count + 16'd1;
                    end
                end
                S_WAIT, S_DRAIN: begin
                    if (i_mem_ack) begin
                        // Data tagged with the requested address, not the current pc.
                        if ((r_state == S_WAIT) && !i_flush) begin
                            r_buf_data  <= i_mem_rdata;
                            r_buf_addr  <= r_req_addr;
                            r_buf_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (i_flush && (r_state != S_ERROR)) r_buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle vector table plus hand sequences for flush,
// timeout and reset corners; memory requests are checked against a scoreboard queue.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc;
    logic        flush;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        fetch_err;
    logic [15:0] miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb_q[$];
    logic       prev_req = 1'b0;

    typedef struct {
        logic [9:0]  pc;
        logic        ack;
        logic [15:0] rdata;
        logic        push;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic        exp_req;
        logic [9:0]  exp_addr;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t tbl[24];

    instr_fetch_unit #(
        .ADDR_W(10), .DATA_W(16), .TIMEOUT(4), .NOP_INSTR(16'h0000)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_pc(pc),
        .i_flush(flush),
        .o_instr(instr),
        .o_instr_valid(instr_valid),
        .o_stall(stall),
        .o_mem_req(mem_req),
        .o_mem_addr(mem_addr),
        .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata),
        .o_fetch_err(fetch_err),
        .o_miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each new request (rising mem_req) must match the oldest expected address.
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_req", {22'd0, mem_addr}, 32'h3FF_FFFF);
            end else begin
                chk("sb_req_addr", {22'd0, mem_addr}, {22'd0, sb_q.pop_front()});
            end
        end
        prev_req <= mem_req;
    end

    task automatic cyc(input logic [9:0] p, input logic fl, input logic ack,
                       input logic [15:0] rd, input logic rst, input logic push);
        @(posedge clk);
        #1;
        pc        = p;
        flush     = fl;
        mem_ack   = ack;
        mem_rdata = rd;
        reset     = rst;
        if (push) sb_q.push_back(p);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                           input logic req, input logic [9:0] addr,
                           input logic [15:0] miss, input logic err);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".instr"}, {16'd0, instr}, {16'd0, ins});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, ~v});
        chk({tag, ".req"},   {31'd0, mem_req}, {31'd0, req});
        chk({tag, ".addr"},  {22'd0, mem_addr}, {22'd0, addr});
        chk({tag, ".miss"},  {16'd0, miss_count}, {16'd0, miss});
        chk({tag, ".err"},   {31'd0, fetch_err}, {31'd0, err});
    endtask

    function automatic vec_t mk(input logic [9:0] p, input logic ack, input logic [15:0] rd,
                                input logic push, input logic v, input logic [15:0] ins,
                                input logic req, input logic [9:0] addr, input logic [15:0] miss);
        vec_t r;
        r.pc = p; r.ack = ack; r.rdata = rd; r.push = push;
        r.exp_valid = v; r.exp_instr = ins; r.exp_req = req;
        r.exp_addr = addr; r.exp_miss = miss;
        return r;
    endfunction

    initial begin
        // Rows: drive inputs, then check outputs in the same cycle.
        tbl[0]  = mk(10'h000, 0, 16'h0000, 1, 0, 16'h0000, 0, 10'h000, 16'd0);
        tbl[1]  = mk(10'h000, 1, 16'h1234, 0, 0, 16'h0000, 1, 10'h000, 16'd1);
        for (int i = 2; i <= 12; i++)
            tbl[i] = mk(10'h000, 0, 16'h0000, 0, 1, 16'h1234, 0, 10'h000, 16'd1);
        tbl[13] = mk(10'h001, 0, 16'h0000, 1, 0, 16'h0000, 0, 10'h000, 16'd1);
        tbl[14] = mk(10'h001, 0, 16'h0000, 0, 0, 16'h0000, 1, 10'h001, 16'd2);
        tbl[15] = mk(10'h001, 0, 16'h0000, 0, 0, 16'h0000, 1, 10'h001, 16'd2);
        tbl[16] = mk(10'h001, 1, 16'hABCD, 0, 0, 16'h0000, 1, 10'h001, 16'd2);
        tbl[17] = mk(10'h001, 0, 16'h0000, 0, 1, 16'hABCD, 0, 10'h001, 16'd2);
        tbl[18] = mk(10'h005, 0, 16'h0000, 1, 0, 16'h0000, 0, 10'h001, 16'd2);
        tbl[19] = mk(10'h006, 0, 16'h0000, 0, 0, 16'h0000, 1, 10'h005, 16'd3);
        tbl[20] = mk(10'h006, 1, 16'h5555, 0, 0, 16'h0000, 1, 10'h005, 16'd3);
        tbl[21] = mk(10'h006, 0, 16'h0000, 1, 0, 16'h0000, 0, 10'h005, 16'd3);
        tbl[22] = mk(10'h006, 1, 16'h6666, 0, 0, 16'h0000, 1, 10'h006, 16'd4);
        tbl[23] = mk(10'h006, 0, 16'h0000, 0, 1, 16'h6666, 0, 10'h006, 16'd4);

        reset = 1'b1; pc = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_out("reset", 0, 16'h0000, 0, 10'h000, 16'd0, 0);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].pc, 1'b0, tbl[i].ack, tbl[i].rdata, 1'b0, tbl[i].push);
            chk_out($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_instr,
                    tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_miss, 1'b0);
        end

        // Flush in IDLE suppresses the request and invalidates the buffer.
        cyc(10'h007, 1, 0, 16'h0, 0, 0); chk_out("fl_idle0", 0, 16'h0, 0, 10'h006, 16'd4, 0);
        cyc(10'h006, 1, 0, 16'h0, 0, 0); chk_out("fl_idle1", 0, 16'h0, 0, 10'h006, 16'd4, 0);
        // Flush during WAIT: request drains, data discarded, fresh fetch follows.
        cyc(10'h007, 0, 0, 16'h0, 0, 1);    chk_out("fl_c0", 0, 16'h0, 0, 10'h006, 16'd4, 0);
        cyc(10'h007, 1, 0, 16'h0, 0, 0);    chk_out("fl_c1", 0, 16'h0, 1, 10'h007, 16'd5, 0);
        cyc(10'h007, 0, 0, 16'h0, 0, 0);    chk_out("fl_c2", 0, 16'h0, 1, 10'h007, 16'd5, 0);
        cyc(10'h007, 0, 1, 16'h7777, 0, 0); chk_out("fl_c3", 0, 16'h0, 1, 10'h007, 16'd5, 0);
        cyc(10'h007, 0, 0, 16'h0, 0, 1);    chk_out("fl_c4", 0, 16'h0, 0, 10'h007, 16'd5, 0);
        cyc(10'h007, 0, 1, 16'h7878, 0, 0); chk_out("fl_c5", 0, 16'h0, 1, 10'h007, 16'd6, 0);
        cyc(10'h007, 0, 0, 16'h0, 0, 0);    chk_out("fl_c6", 1, 16'h7878, 0, 10'h007, 16'd6, 0);

        // Ack on the last allowed WAIT cycle wins over the timeout.
        cyc(10'h009, 0, 0, 16'h0, 0, 1); chk_out("ack4_0", 0, 16'h0, 0, 10'h007, 16'd6, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(10'h009, 0, 0, 16'h0, 0, 0);
            chk_out($sformatf("ack4_%0d", k), 0, 16'h0, 1, 10'h009, 16'd7, 0);
        end
        cyc(10'h009, 0, 1, 16'h9999, 0, 0); chk_out("ack4_4", 0, 16'h0, 1, 10'h009, 16'd7, 0);
        cyc(10'h009, 0, 0, 16'h0, 0, 0);    chk_out("ack4_5", 1, 16'h9999, 0, 10'h009, 16'd7, 0);

        // No ack: exactly four request cycles, then sticky error.
        cyc(10'h008, 0, 0, 16'h0, 0, 1); chk_out("to_0", 0, 16'h0, 0, 10'h009, 16'd7, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(10'h008, 0, 0, 16'h0, 0, 0);
            chk_out($sformatf("to_%0d", k), 0, 16'h0, 1, 10'h008, 16'd8, 0);
        end
        cyc(10'h009, 1, 0, 16'h0, 0, 0);    chk_out("to_5", 0, 16'h0, 0, 10'h008, 16'd8, 1);
        cyc(10'h009, 0, 1, 16'h1111, 0, 0); chk_out("to_6", 0, 16'h0, 0, 10'h008, 16'd8, 1);
        cyc(10'h009, 0, 0, 16'h0, 0, 0);    chk_out("to_7", 0, 16'h0, 0, 10'h008, 16'd8, 1);

        // Reset clears the error; then reset mid-WAIT with a stray late ack.
        cyc(10'h00A, 0, 0, 16'h0, 1, 0);
        cyc(10'h00A, 0, 0, 16'h0, 0, 1);    chk_out("rst_0", 0, 16'h0, 0, 10'h000, 16'd0, 0);
        cyc(10'h00A, 0, 0, 16'h0, 1, 0);    chk_out("rst_1", 0, 16'h0, 1, 10'h00A, 16'd1, 0);
        cyc(10'h00A, 0, 1, 16'hDEAD, 0, 1); chk_out("rst_2", 0, 16'h0, 0, 10'h000, 16'd0, 0);
        cyc(10'h00A, 0, 0, 16'h0, 0, 0);    chk_out("rst_3", 0, 16'h0, 1, 10'h00A, 16'd1, 0);
        cyc(10'h00A, 0, 1, 16'hBEEF, 0, 0); chk_out("rst_4", 0, 16'h0, 1, 10'h00A, 16'd1, 0);
        cyc(10'h00A, 0, 0, 16'h0, 0, 0);    chk_out("rst_5", 1, 16'hBEEF, 0, 10'h00A, 16'd1, 0);

        cyc(10'h00A, 0, 0, 16'h0, 0, 0);
        chk("sb_pending", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
